// File: rtl/csr_access_ctrl_pkg.sv
// Shared CSR addresses, mstatus field positions and sequencer states
// for the CSR access controller.
package csr_access_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EX_WR,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_TVAL,
        ST_T_MST,
        ST_T_VEC,
        ST_R_MST,
        ST_R_EPC
    } state_e;

    // Address space 0xC00-0xFFF is read-only by CSR address encoding.
    function automatic logic ro_csr(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_access_ctrl_trap_vec_calc.sv
// Trap target from mtvec and mcause: direct mode jumps to base,
// vectored mode adds 4*cause for interrupts (wraps modulo 2^XLEN).
module csr_access_ctrl_trap_vec_calc
    import csr_access_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_cause,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_offset;
    logic            w_vectored;
    logic            w_unused_cause;

    assign w_base     = {i_mtvec[XLEN-1:2], 2'b00};
    // 4*cause[XLEN-2:0]; the top cause bit falls off the end.
    assign w_offset   = {i_cause[XLEN-3:0], 2'b00};
    assign w_vectored = (i_mtvec[1:0] == MTVEC_MODE_VECTORED)
                      & i_cause[XLEN-1];
    assign w_unused_cause = i_cause[XLEN-2];

    assign o_pc = w_vectored ? (w_base + w_offset) : w_base;

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR write-port sequencer for EX writes, trap entry and mret.
// Optional: define CSR_ACC_ILLEGAL_CHK_EN to drop EX writes to read-only CSRs.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter logic [1:0] MPP_MODE = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_req_valid,
    output logic            ex_req_ready,
    input  logic [11:0]     ex_req_addr,
    input  logic [XLEN-1:0] ex_req_wdata,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    output logic            trap_ack,
    input  logic            mret_req,
    output logic            mret_ack,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            csr_illegal
);

    state_e          r_state;
    state_e          w_next;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] w_vec_pc;
    logic [XLEN-1:0] w_trap_mst;
    logic [XLEN-1:0] w_mret_mst;
    logic            w_ex_hs;
    logic            w_ex_drop;
    logic            w_unused_pc;

    assign ex_req_ready = (r_state == ST_IDLE) & ~trap_req & ~mret_req;
    assign w_ex_hs      = ex_req_valid & ex_req_ready;
    assign busy         = (r_state != ST_IDLE);
    assign w_unused_pc  = ^r_pc[1:0];

`ifdef CSR_ACC_ILLEGAL_CHK_EN
    assign w_ex_drop = ro_csr(r_addr);
`else
    assign w_ex_drop = 1'b0;
`endif

    csr_access_ctrl_trap_vec_calc #(
        .XLEN (XLEN)
    ) u_vec (
        .i_mtvec (csr_rdata),
        .i_cause (r_cause),
        .o_pc    (w_vec_pc)
    );

    // mstatus images written on trap entry and on mret
    always_comb begin
        w_trap_mst = r_mstatus;
        w_trap_mst[MSTATUS_MPIE] = r_mstatus[MSTATUS_MIE];
        w_trap_mst[MSTATUS_MIE]  = 1'b0;
        w_trap_mst[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_MODE;
        w_mret_mst = csr_rdata;
        w_mret_mst[MSTATUS_MIE]  = csr_rdata[MSTATUS_MPIE];
        w_mret_mst[MSTATUS_MPIE] = 1'b1;
        w_mret_mst[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_MODE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Captured request data and the mstatus snapshot taken in T_EPC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cause   <= '0;
            r_pc      <= '0;
            r_tval    <= '0;
            r_mstatus <= '0;
        end else begin
            if ((r_state == ST_IDLE) && trap_req) begin
                r_cause <= trap_cause;
                r_pc    <= trap_pc;
                r_tval  <= trap_tval;
            end
            if (w_ex_hs) begin
                r_addr  <= ex_req_addr;
                r_wdata <= ex_req_wdata;
            end
            if (r_state == ST_T_EPC) begin
                r_mstatus <= csr_rdata;
            end
        end
    end

    // Next state; in IDLE a trap beats mret, which beats an EX write
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (trap_req) begin
                    w_next = ST_T_EPC;
                end else if (mret_req) begin
                    w_next = ST_R_MST;
                end else if (ex_req_valid) begin
                    w_next = ST_EX_WR;
                end
            end
            ST_EX_WR:   w_next = ST_IDLE;
            ST_T_EPC:   w_next = ST_T_CAUSE;
            ST_T_CAUSE: w_next = ST_T_TVAL;
            ST_T_TVAL:  w_next = ST_T_MST;
            ST_T_MST:   w_next = ST_T_VEC;
            ST_T_VEC:   w_next = ST_IDLE;
            ST_R_MST:   w_next = ST_R_EPC;
            ST_R_EPC:   w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from state and captured registers
    always_comb begin
        csr_raddr      = '0;
        csr_wen        = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_ack       = 1'b0;
        mret_ack       = 1'b0;
        csr_illegal    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
            end
            ST_EX_WR: begin
                csr_wen     = ~w_ex_drop;
                csr_waddr   = r_addr;
                csr_wdata   = r_wdata;
                csr_illegal = w_ex_drop;
            end
            ST_T_EPC: begin
                csr_raddr = CSR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = {r_pc[XLEN-1:2], 2'b00};
            end
            ST_T_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = r_cause;
            end
            ST_T_TVAL: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = r_tval;
            end
            ST_T_MST: begin
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = w_trap_mst;
            end
            ST_T_VEC: begin
                csr_raddr      = CSR_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = w_vec_pc;
                trap_ack       = 1'b1;
            end
            ST_R_MST: begin
                csr_raddr = CSR_MSTATUS;
                csr_wen   = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = w_mret_mst;
            end
            ST_R_EPC: begin
                csr_raddr      = CSR_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
                mret_ack       = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl: directed and random CSR,
// trap and mret traffic checked against an architectural model.
module tb_csr_access_ctrl;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req_valid;
    logic        ex_req_ready;
    logic [11:0] ex_req_addr;
    logic [31:0] ex_req_wdata;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        trap_ack;
    logic        mret_req;
    logic        mret_ack;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        csr_illegal;

    csr_access_ctrl #(.XLEN(32), .MPP_MODE(2'b11)) dut (
        .clk(clk), .rst(rst),
        .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready),
        .ex_req_addr(ex_req_addr), .ex_req_wdata(ex_req_wdata),
        .trap_req(trap_req), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .trap_ack(trap_ack),
        .mret_req(mret_req), .mret_ack(mret_ack),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .csr_illegal(csr_illegal)
    );

    always #5 clk = ~clk;

    // CSR file seen by the DUT: combinational read, clocked write
    logic [31:0] mem [0:4095];
    assign csr_rdata = mem[csr_raddr];
    always @(posedge clk) if (csr_wen) mem[csr_waddr] <= csr_wdata;

    typedef struct packed { logic [11:0] a; logic [31:0] d; } wr_t;
    typedef struct packed { logic [31:0] pc; logic trap; } rd_t;

    wr_t         wq[$];
    rd_t         rq[$];
    int          exp_ill;
    logic [31:0] m [0:4095];
    int          n_tests;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no response, expected one within bound", name);
    endtask

    // Architectural model
    function automatic logic [31:0] mdl_trap_pc(input logic [31:0] tvec,
                                                input logic [31:0] cause);
        logic [31:0] base;
        base = tvec & 32'hFFFF_FFFC;
        if (tvec[1:0] == 2'b01 && cause[31])
            return base + (cause & 32'h7FFF_FFFF) * 32'd4;
        return base;
    endfunction

    function automatic logic [31:0] mdl_trap_mst(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (s[3] ? 32'h80 : 32'h0) | 32'h1800;
    endfunction

    function automatic logic [31:0] mdl_mret_mst(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (s[7] ? 32'h8 : 32'h0)
             | 32'h80 | 32'h1800;
    endfunction

    function automatic void exp_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
        m[a] = d;
    endfunction

    function automatic void exp_rd(input logic [31:0] pc, input logic trap);
        rd_t r;
        r.pc = pc;
        r.trap = trap;
        rq.push_back(r);
    endfunction

    // Monitor: compare every write / redirect / illegal pulse with the queues
    always @(negedge clk) begin : mon
        wr_t e;
        rd_t r;
        if (rst === 1'b0) begin
            if (csr_wen) begin
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%h data 0x%h, expected none",
                             csr_waddr, csr_wdata);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(csr_waddr), 32'(e.a));
                    chk("wr_data", csr_wdata, e.d);
                end
            end
            if (redirect_valid) begin
                if (rq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_redirect: got pc 0x%h, expected none",
                             redirect_pc);
                end else begin
                    r = rq.pop_front();
                    chk("redirect_pc", redirect_pc, r.pc);
                    chk("ack_kind", 32'({trap_ack, mret_ack}),
                        r.trap ? 32'd2 : 32'd1);
                end
            end else if (trap_ack || mret_ack) begin
                chk("ack_without_redirect", 32'({trap_ack, mret_ack}), 32'd0);
            end
            if (csr_illegal) begin
                chk("illegal_expected", 32'(exp_ill > 0), 32'd1);
                if (exp_ill > 0) exp_ill--;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        ex_req_valid = 1'b0;
        ex_req_addr = '0;
        ex_req_wdata = '0;
        trap_req = 1'b0;
        trap_cause = '0;
        trap_pc = '0;
        trap_tval = '0;
        mret_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ex_req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wen", 32'(csr_wen), 32'd0);
        chk("rst_waddr", 32'(csr_waddr), 32'd0);
        chk("rst_wdata", csr_wdata, 32'd0);
        chk("rst_raddr", 32'(csr_raddr), 32'd0);
        chk("rst_redirect", 32'({redirect_valid, trap_ack, mret_ack}), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_illegal", 32'(csr_illegal), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic ex_write(input logic [11:0] a, input logic [31:0] d,
                            input bit keep, output time t);
        int n;
        bit acc;
        bit ill;
        n = 0;
        acc = 0;
        t = 0;
        ex_req_valid = 1'b1;
        ex_req_addr = a;
        ex_req_wdata = d;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = ex_req_ready;
            @(posedge clk);
            n++;
        end
        t = $time;
        #1;
        if (!keep || !acc) ex_req_valid = 1'b0;
        if (!acc) begin
            fail_now("ex_accept_timeout");
            return;
        end
`ifdef CSR_ACC_ILLEGAL_CHK_EN
        ill = (a[11:10] == 2'b11);
`else
        ill = 1'b0;
`endif
        if (ill) exp_ill++;
        else exp_wr(a, d);
        @(negedge clk);
        chk("ex_ready_low", 32'(ex_req_ready), 32'd0);
        chk("ex_wen_next", 32'(csr_wen), 32'(!ill));
        chk("ex_illegal", 32'(csr_illegal), 32'(ill));
        @(posedge clk);
        #1;
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval);
        int n;
        bit acc;
        trap_req = 1'b1;
        trap_pc = pc;
        trap_cause = cause;
        trap_tval = tval;
        n = 0;
        acc = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = !busy;
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            fail_now("trap_accept_timeout");
            #1 trap_req = 1'b0;
            return;
        end
        exp_wr(A_MEPC, pc & 32'hFFFF_FFFC);
        exp_wr(A_MCAUSE, cause);
        exp_wr(A_MTVAL, tval);
        exp_wr(A_MSTATUS, mdl_trap_mst(m[A_MSTATUS]));
        exp_rd(mdl_trap_pc(m[A_MTVEC], cause), 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trap_ack && n < 12);
        chk("trap_ack_latency", 32'(n), 32'd5);
        @(posedge clk);
        #1;
        trap_req = 1'b0;
    endtask

    task automatic do_mret();
        int n;
        bit acc;
        mret_req = 1'b1;
        n = 0;
        acc = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = !busy && !trap_req;
            @(posedge clk);
            n++;
        end
        if (!acc) begin
            fail_now("mret_accept_timeout");
            #1 mret_req = 1'b0;
            return;
        end
        exp_wr(A_MSTATUS, mdl_mret_mst(m[A_MSTATUS]));
        exp_rd(m[A_MEPC] & 32'hFFFF_FFFC, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mret_ack && n < 12);
        chk("mret_ack_latency", 32'(n), 32'd2);
        @(posedge clk);
        #1;
        mret_req = 1'b0;
    endtask

    task automatic collide(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [11:0] a,
                           input logic [31:0] d);
        time tt;
        fork
            do_trap(pc, cause, tval);
            do_mret();
            ex_write(a, d, 1'b0, tt);
        join
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        time t [4];
        time tt;
        int  n;
        bit  acc;
        n_tests = 0;
        n_fail = 0;
        exp_ill = 0;
        for (int i = 0; i < 4096; i++) m[i] = '0;

        do_reset();

        ex_write(12'h340, 32'hDEAD_BEEF, 1'b0, tt);

        for (int i = 0; i < 4; i++)
            ex_write(12'h340 + 12'(i), $urandom, (i < 3), t[i]);
        for (int i = 1; i < 4; i++)
            chk("b2b_interval", 32'(t[i] - t[i-1]), 32'd20);

        ex_write(A_MSTATUS, 32'h0000_0008, 1'b0, tt);
        ex_write(A_MTVEC, 32'h8000_0100, 1'b0, tt);
        ex_write(A_MTVAL, 32'h0000_1111, 1'b0, tt);
        do_trap(32'h0000_1236, 32'd2, 32'h55);
        chk("direct_mepc", mem[A_MEPC], 32'h0000_1234);
        chk("direct_mstatus", mem[A_MSTATUS], 32'h0000_1880);

        ex_write(A_MTVEC, 32'h8000_0101, 1'b0, tt);
        do_trap(32'h0000_2000, 32'h8000_0007, 32'h0);
        do_trap(32'h0000_2004, 32'd2, 32'h0);

        ex_write(A_MTVEC, 32'hFFFF_FF01, 1'b0, tt);
        do_trap(32'h0000_3000, 32'h8000_0010, 32'h7);

        ex_write(A_MSTATUS, 32'h0000_1880, 1'b0, tt);
        ex_write(A_MEPC, 32'h0000_2000, 1'b0, tt);
        do_mret();
        chk("mret_mstatus", mem[A_MSTATUS], 32'h0000_1888);

        ex_write(A_MTVEC, 32'h8000_0100, 1'b0, tt);
        collide(32'h0000_5000, 32'd11, 32'h99, 12'h340, 32'hCAFE_F00D);

        // Reset while the trap sequence sits in T_TVAL
        trap_req = 1'b1;
        trap_pc = 32'h0000_4442;
        trap_cause = 32'd5;
        trap_tval = 32'h0000_ABCD;
        n = 0;
        acc = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = !busy;
            @(posedge clk);
            n++;
        end
        if (!acc) fail_now("rst_trap_accept_timeout");
        exp_wr(A_MEPC, 32'h0000_4440);
        exp_wr(A_MCAUSE, 32'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        trap_req = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wen", 32'(csr_wen), 32'd0);
        chk("midrst_redirect", 32'({redirect_valid, trap_ack}), 32'd0);
        chk("midrst_ready", 32'(ex_req_ready), 32'd1);
        chk("midrst_raddr", 32'(csr_raddr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_mstatus_kept", mem[A_MSTATUS], m[A_MSTATUS]);
        chk("midrst_mtval_kept", mem[A_MTVAL], m[A_MTVAL]);

        ex_write(12'hF11, 32'h1234_5678, 1'b0, tt);

        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [31:0] c;
            op = $urandom_range(0, 11);
            c = $urandom;
            if ($urandom_range(0, 1) == 1) c = {c[31], 23'h0, c[7:0]};
            case (op)
                0, 1, 2, 3: ex_write(12'($urandom), $urandom, 1'b0, tt);
                4: ex_write(A_MSTATUS, $urandom, 1'b0, tt);
                5: ex_write(A_MTVEC, $urandom, 1'b0, tt);
                6: ex_write(A_MEPC, $urandom, 1'b0, tt);
                7: ex_write({2'b11, 10'($urandom)}, $urandom, 1'b0, tt);
                8, 9: do_trap($urandom, c, $urandom);
                10: do_mret();
                default: collide($urandom, c, $urandom,
                                 12'($urandom), $urandom);
            endcase
        end

        repeat (4) @(posedge clk);
        #1;
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        chk("illegal_drained", 32'(exp_ill), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
